// File: rtl/vec_writeback_pkg.sv
// Shared codes for the writeback/memory stage: FSM/mem_wr codes, instruction types, opcode IDs.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package vec_writeback_pkg;

  // FSM state codes; IDLE/LD/ST double as mem_wr request codes
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LD   = 2'd1;
  localparam logic [1:0] ST   = 2'd2;

  // Instruction type codes
  localparam logic [1:0] DONE = 2'd0;
  localparam logic [1:0] REG  = 2'd1;
  localparam logic [1:0] MEM  = 2'd2;
  localparam logic [1:0] BR   = 2'd3;

  // Opcode IDs; loads and stores are kept contiguous so range checks work
  localparam logic [5:0] ADD  = 6'd1;
  localparam logic [5:0] JALR = 6'd2;
  localparam logic [5:0] BEQ  = 6'd3;
  localparam logic [5:0] LB   = 6'd8;
  localparam logic [5:0] LH   = 6'd9;
  localparam logic [5:0] LW   = 6'd10;
  localparam logic [5:0] LBU  = 6'd11;
  localparam logic [5:0] LHU  = 6'd12;
  localparam logic [5:0] SB   = 6'd13;
  localparam logic [5:0] SH   = 6'd14;
  localparam logic [5:0] SW   = 6'd15;
  localparam logic [5:0] VLE  = 6'd16;
  localparam logic [5:0] VSE  = 6'd17;
  localparam logic [5:0] VADD = 6'd18;

  function automatic logic is_load(input logic [5:0] op);
    return (op >= LB) && (op <= LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op >= SB) && (op <= SW);
  endfunction

  // Transfer size in bytes for a scalar memory opcode
  function automatic logic [2:0] mem_len_of(input logic [5:0] op);
    case (op)
      LB, LBU, SB: return 3'd1;
      LH, LHU, SH: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/vec_writeback_ld_extend.sv
// Load-data extender: sign/zero-extends right-aligned load data according to the opcode.
// Latency: combinational.
// Backpressure: none.
import vec_writeback_pkg::*;

module vec_writeback_ld_extend #(
  parameter int XLEN = 32
) (
  input  logic [5:0]      name,
  input  logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] ext_data
);

  // Select the extension rule; word loads and unknown opcodes pass through
  always_comb begin
    ext_data = ld_data;
    case (name)
      LB:      ext_data = {{(XLEN-8){ld_data[7]}}, ld_data[7:0]};
      LH:      ext_data = {{(XLEN-16){ld_data[15]}}, ld_data[15:0]};
      LBU:     ext_data = {{(XLEN-8){1'b0}}, ld_data[7:0]};
      LHU:     ext_data = {{(XLEN-16){1'b0}}, ld_data[15:0]};
      default: ext_data = ld_data;
    endcase
  end

endmodule

// File: rtl/vec_writeback.sv
// Writeback/memory stage: scalar/vector register writes, branch redirects, scalar and unit-stride vector loads/stores.
// Latency: 1 cycle for register/branch results; memory results 1 cycle after mem_rdy, one element per request.
// Backpressure: wb_rdy low while a transfer is in flight or after halt; rdy low freezes everything.
import vec_writeback_pkg::*;

module vec_writeback #(
  parameter int XLEN  = 32,
  parameter int LANES = 4,
  parameter int CNT_W = $clog2(LANES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rd_rdy,
  input  logic                  is_vec,
  input  logic [1:0]            op_type,
  input  logic [5:0]            name,
  input  logic [4:0]            rd,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       val,
  input  logic [LANES*XLEN-1:0] vval,
  input  logic [XLEN-1:0]       st_data,
  input  logic [LANES*XLEN-1:0] vst_data,
  output logic                  wb_rdy,
  output logic                  br_rdy,
  output logic [XLEN-1:0]       pc_out,
  output logic [4:0]            reg_rd,
  output logic [XLEN-1:0]       reg_out,
  output logic                  vreg_we,
  output logic [4:0]            vreg_rd,
  output logic [LANES*XLEN-1:0] vreg_out,
  input  logic                  mem_rdy,
  input  logic [XLEN-1:0]       ld_data,
  output logic [1:0]            mem_wr,
  output logic [2:0]            mem_len,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_data,
  output logic                  halt
);

  // Bubble between vector elements; never visible on mem_wr
  localparam logic [1:0] GAP = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_nx;
  logic [4:0]            rd_q, rd_d;
  logic [5:0]            name_q, name_d;
  logic                  vec_q, vec_d;
  logic [LANES*XLEN-1:0] vbuf_q, vbuf_d;
  logic                  wb_rdy_q, wb_rdy_d;
  logic                  br_rdy_q, br_rdy_d;
  logic [XLEN-1:0]       pc_out_q, pc_out_d;
  logic [4:0]            reg_rd_q, reg_rd_d;
  logic [XLEN-1:0]       reg_out_q, reg_out_d;
  logic                  vreg_we_q, vreg_we_d;
  logic [4:0]            vreg_rd_q, vreg_rd_d;
  logic [LANES*XLEN-1:0] vreg_out_q, vreg_out_d;
  logic [1:0]            mem_wr_q, mem_wr_d;
  logic [2:0]            mem_len_q, mem_len_d;
  logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_data_q, mem_data_d;
  logic                  halt_q, halt_d;
  logic [XLEN-1:0]       ext_data;
  logic                  last_elem;

  vec_writeback_ld_extend #(.XLEN(XLEN)) u_ld_extend (
    .name     (name_q),
    .ld_data  (ld_data),
    .ext_data (ext_data)
  );

  assign last_elem = (cnt_q == CNT_W'(LANES - 1));
  assign cnt_nx    = last_elem ? '0 : cnt_q + CNT_W'(1);

  // Next-state and output decode; pulse outputs default low every cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    name_d     = name_q;
    vec_d      = vec_q;
    vbuf_d     = vbuf_q;
    wb_rdy_d   = wb_rdy_q;
    br_rdy_d   = 1'b0;
    pc_out_d   = pc_out_q;
    reg_rd_d   = '0;
    reg_out_d  = reg_out_q;
    vreg_we_d  = 1'b0;
    vreg_rd_d  = vreg_rd_q;
    vreg_out_d = vreg_out_q;
    mem_len_d  = mem_len_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    halt_d     = halt_q;
    case (state_q)
      IDLE: begin
        if (rd_rdy && wb_rdy_q) begin
          rd_d   = rd;
          name_d = name;
          vec_d  = is_vec;
          cnt_d  = '0;
          if (op_type == DONE) begin
            halt_d   = 1'b1;
            wb_rdy_d = 1'b0;
          end else if (is_vec) begin
            if (op_type == REG) begin
              vreg_we_d  = 1'b1;
              vreg_rd_d  = rd;
              vreg_out_d = vval;
            end else if (op_type == MEM && (name == VLE || name == VSE)) begin
              state_d    = (name == VLE) ? LD : ST;
              mem_addr_d = val;
              mem_len_d  = 3'd4;
              mem_data_d = vst_data[XLEN-1:0];
              vbuf_d     = vst_data;
              wb_rdy_d   = 1'b0;
            end
          end else if (op_type == BR) begin
            br_rdy_d = 1'b1;
            pc_out_d = (val != '0) ? pc + imm : pc + XLEN'(4);
          end else if (is_load(name) || is_store(name)) begin
            state_d    = is_load(name) ? LD : ST;
            mem_addr_d = val;
            mem_len_d  = mem_len_of(name);
            mem_data_d = st_data;
            wb_rdy_d   = 1'b0;
          end else if (op_type == REG) begin
            reg_rd_d  = rd;
            reg_out_d = val;
            if (name == JALR) begin
              reg_out_d = pc + XLEN'(4);
              br_rdy_d  = 1'b1;
              pc_out_d  = val;
            end
          end
        end
      end
      LD: begin
        if (mem_rdy) begin
          if (!vec_q) begin
            reg_rd_d  = rd_q;
            reg_out_d = ext_data;
            state_d   = IDLE;
            wb_rdy_d  = 1'b1;
          end else begin
            for (int i = 0; i < LANES; i++) begin
              if (cnt_q == CNT_W'(i)) vbuf_d[i*XLEN +: XLEN] = ld_data;
            end
            cnt_d = cnt_nx;
            if (last_elem) begin
              vreg_we_d  = 1'b1;
              vreg_rd_d  = rd_q;
              vreg_out_d = vbuf_d;
              state_d    = IDLE;
              wb_rdy_d   = 1'b1;
            end else begin
              state_d = GAP;
            end
          end
        end
      end
      ST: begin
        if (mem_rdy) begin
          if (!vec_q || last_elem) begin
            cnt_d    = '0;
            state_d  = IDLE;
            wb_rdy_d = 1'b1;
          end else begin
            cnt_d   = cnt_nx;
            state_d = GAP;
            for (int i = 0; i < LANES; i++) begin
              if (cnt_nx == CNT_W'(i)) mem_data_d = vbuf_q[i*XLEN +: XLEN];
            end
          end
        end
      end
      default: begin
        // GAP: step to the next word and reissue the same kind of request
        state_d    = (name_q == VSE) ? ST : LD;
        mem_addr_d = mem_addr_q + XLEN'(4);
      end
    endcase
    mem_wr_d = (state_d == GAP) ? IDLE : state_d;
  end

  // State and output registers; rdy low holds everything, reset drops any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      name_q     <= '0;
      vec_q      <= 1'b0;
      vbuf_q     <= '0;
      wb_rdy_q   <= 1'b1;
      br_rdy_q   <= 1'b0;
      pc_out_q   <= '0;
      reg_rd_q   <= '0;
      reg_out_q  <= '0;
      vreg_we_q  <= 1'b0;
      vreg_rd_q  <= '0;
      vreg_out_q <= '0;
      mem_wr_q   <= IDLE;
      mem_len_q  <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      halt_q     <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      name_q     <= name_d;
      vec_q      <= vec_d;
      vbuf_q     <= vbuf_d;
      wb_rdy_q   <= wb_rdy_d;
      br_rdy_q   <= br_rdy_d;
      pc_out_q   <= pc_out_d;
      reg_rd_q   <= reg_rd_d;
      reg_out_q  <= reg_out_d;
      vreg_we_q  <= vreg_we_d;
      vreg_rd_q  <= vreg_rd_d;
      vreg_out_q <= vreg_out_d;
      mem_wr_q   <= mem_wr_d;
      mem_len_q  <= mem_len_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      halt_q     <= halt_d;
    end
  end

  assign wb_rdy   = wb_rdy_q;
  assign br_rdy   = br_rdy_q;
  assign pc_out   = pc_out_q;
  assign reg_rd   = reg_rd_q;
  assign reg_out  = reg_out_q;
  assign vreg_we  = vreg_we_q;
  assign vreg_rd  = vreg_rd_q;
  assign vreg_out = vreg_out_q;
  assign mem_wr   = mem_wr_q;
  assign mem_len  = mem_len_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign halt     = halt_q;

endmodule

// File: tb/tb_vec_writeback.sv
// Directed bench for vec_writeback with hand-computed expectations.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: memory handshake and rdy stalls are driven explicitly.
module tb_vec_writeback;
  import vec_writeback_pkg::*;

  localparam int XLEN  = 32;
  localparam int LANES = 4;

  logic                  clk = 1'b0;
  logic                  rst, rdy, rd_rdy, is_vec, mem_rdy;
  logic [1:0]            op_type;
  logic [5:0]            name;
  logic [4:0]            rd;
  logic [XLEN-1:0]       pc, imm, val, st_data, ld_data;
  logic [LANES*XLEN-1:0] vval, vst_data;
  logic                  wb_rdy, br_rdy, vreg_we, halt;
  logic [XLEN-1:0]       pc_out, reg_out, mem_addr, mem_data;
  logic [4:0]            reg_rd, vreg_rd;
  logic [LANES*XLEN-1:0] vreg_out;
  logic [1:0]            mem_wr;
  logic [2:0]            mem_len;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vec_writeback #(.XLEN(XLEN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rd_rdy(rd_rdy), .is_vec(is_vec),
    .op_type(op_type), .name(name), .rd(rd), .pc(pc), .imm(imm), .val(val),
    .vval(vval), .st_data(st_data), .vst_data(vst_data),
    .wb_rdy(wb_rdy), .br_rdy(br_rdy), .pc_out(pc_out), .reg_rd(reg_rd),
    .reg_out(reg_out), .vreg_we(vreg_we), .vreg_rd(vreg_rd), .vreg_out(vreg_out),
    .mem_rdy(mem_rdy), .ld_data(ld_data), .mem_wr(mem_wr), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [1:0] t, input logic [5:0] n,
                       input logic [4:0] r, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] vl);
    is_vec = v; op_type = t; name = n; rd = r; pc = p; imm = i; val = vl;
    rd_rdy = 1'b1;
    step();
    rd_rdy = 1'b0;
  endtask

  task automatic mem_ack(input logic [31:0] d);
    ld_data = d;
    mem_rdy = 1'b1;
    step();
    mem_rdy = 1'b0;
  endtask

  logic [31:0] lane_dat [LANES];

  initial begin
    rst = 1'b1; rdy = 1'b1; rd_rdy = 1'b0; is_vec = 1'b0; mem_rdy = 1'b0;
    op_type = REG; name = '0; rd = '0; pc = '0; imm = '0; val = '0;
    st_data = '0; ld_data = '0; vval = '0; vst_data = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_wb_rdy", wb_rdy, 1);
    check("rst_br_rdy", br_rdy, 0);
    check("rst_reg_rd", reg_rd, 0);
    check("rst_vreg_we", vreg_we, 0);
    check("rst_mem_wr", mem_wr, IDLE);
    check("rst_halt", halt, 0);
    check("rst_reg_out", reg_out, 0);

    // Scalar ADD: one-cycle register write
    issue(0, REG, ADD, 5, 32'h0, 32'h0, 32'h1234);
    check("add_reg_rd", reg_rd, 5);
    check("add_reg_out", reg_out, 32'h1234);
    check("add_br_rdy", br_rdy, 0);
    step();
    check("add_reg_rd_drop", reg_rd, 0);

    // Branch taken / not taken
    issue(0, BR, BEQ, 0, 32'h100, 32'h20, 32'h1);
    check("br_t_rdy", br_rdy, 1);
    check("br_t_pc", pc_out, 32'h120);
    step();
    check("br_rdy_drop", br_rdy, 0);
    issue(0, BR, BEQ, 0, 32'h100, 32'h20, 32'h0);
    check("br_nt_pc", pc_out, 32'h104);

    // JALR: link and redirect together
    issue(0, REG, JALR, 1, 32'h300, 32'h0, 32'h500);
    check("jalr_reg_rd", reg_rd, 1);
    check("jalr_link", reg_out, 32'h304);
    check("jalr_br_rdy", br_rdy, 1);
    check("jalr_pc", pc_out, 32'h500);

    // LB with an rdy stall while mem_rdy is high
    issue(0, MEM, LB, 9, 32'h0, 32'h0, 32'h40);
    check("lb_mem_wr", mem_wr, LD);
    check("lb_mem_len", mem_len, 1);
    check("lb_mem_addr", mem_addr, 32'h40);
    check("lb_wb_rdy", wb_rdy, 0);
    rdy = 1'b0;
    ld_data = 32'h80;
    mem_rdy = 1'b1;
    step();
    rdy = 1'b1;
    mem_rdy = 1'b0;
    check("stall_mem_wr", mem_wr, LD);
    check("stall_mem_addr", mem_addr, 32'h40);
    check("stall_reg_rd", reg_rd, 0);
    step();
    mem_ack(32'h80);
    check("lb_reg_rd", reg_rd, 9);
    check("lb_reg_out", reg_out, 32'hFFFF_FF80);
    check("lb_mem_wr_done", mem_wr, IDLE);
    check("lb_wb_rdy_done", wb_rdy, 1);

    issue(0, MEM, LBU, 9, 32'h0, 32'h0, 32'h44);
    mem_ack(32'h80);
    check("lbu_reg_out", reg_out, 32'h0000_0080);
    issue(0, MEM, LH, 10, 32'h0, 32'h0, 32'h48);
    check("lh_mem_len", mem_len, 2);
    mem_ack(32'h0000_8001);
    check("lh_reg_out", reg_out, 32'hFFFF_8001);
    issue(0, MEM, LW, 11, 32'h0, 32'h0, 32'h4C);
    check("lw_mem_len", mem_len, 4);
    mem_ack(32'hDEAD_BEEF);
    check("lw_reg_out", reg_out, 32'hDEAD_BEEF);

    // Scalar SH: request carries data, completion writes no register
    st_data = 32'h0000_BEEF;
    issue(0, MEM, SH, 12, 32'h0, 32'h0, 32'h80);
    check("sh_mem_wr", mem_wr, ST);
    check("sh_mem_len", mem_len, 2);
    check("sh_mem_data", mem_data, 32'h0000_BEEF);
    mem_ack(32'h0);
    check("sh_reg_rd", reg_rd, 0);
    check("sh_mem_wr_done", mem_wr, IDLE);
    check("sh_wb_rdy", wb_rdy, 1);

    // Vector register write
    vval = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    issue(1, REG, VADD, 4, 32'h0, 32'h0, 32'h0);
    check("vreg_we", vreg_we, 1);
    check("vreg_rd", vreg_rd, 4);
    check("vreg_out", vreg_out, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    step();
    check("vreg_we_drop", vreg_we, 0);

    // VLE: four word requests separated by GAP cycles, single write at the end
    lane_dat[0] = 32'hA0A0_0000;
    lane_dat[1] = 32'hA1A1_0001;
    lane_dat[2] = 32'hA2A2_0002;
    lane_dat[3] = 32'hA3A3_0003;
    issue(1, MEM, VLE, 3, 32'h0, 32'h0, 32'h200);
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("vle_mem_wr%0d", i), mem_wr, LD);
      check($sformatf("vle_addr%0d", i), mem_addr, 32'h200 + 32'(4 * i));
      check($sformatf("vle_len%0d", i), mem_len, 4);
      step();
      mem_ack(lane_dat[i]);
      if (i < LANES - 1) begin
        check($sformatf("vle_gap%0d", i), mem_wr, IDLE);
        check($sformatf("vle_no_we%0d", i), vreg_we, 0);
        step();
      end
    end
    check("vle_we", vreg_we, 1);
    check("vle_rd", vreg_rd, 3);
    check("vle_data", vreg_out, 128'hA3A3_0003_A2A2_0002_A1A1_0001_A0A0_0000);
    check("vle_wb_rdy", wb_rdy, 1);
    step();
    check("vle_we_drop", vreg_we, 0);

    // VSE interrupted by reset after the second element completes
    vst_data = 128'h0000_0040_0000_0030_0000_0020_0000_0010;
    issue(1, MEM, VSE, 0, 32'h0, 32'h0, 32'h400);
    check("vse_mem_wr0", mem_wr, ST);
    check("vse_addr0", mem_addr, 32'h400);
    check("vse_data0", mem_data, 32'h10);
    mem_ack(32'h0);
    check("vse_gap0", mem_wr, IDLE);
    step();
    check("vse_addr1", mem_addr, 32'h404);
    check("vse_data1", mem_data, 32'h20);
    mem_ack(32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("vse_rst_mem_wr", mem_wr, IDLE);
    check("vse_rst_wb_rdy", wb_rdy, 1);
    check("vse_rst_vreg_we", vreg_we, 0);
    step();
    step();
    check("vse_rst_quiet", mem_wr, IDLE);

    // DONE: halt is sticky and later instructions are ignored
    issue(0, DONE, '0, 0, 32'h0, 32'h0, 32'h0);
    check("done_halt", halt, 1);
    check("done_wb_rdy", wb_rdy, 0);
    issue(0, REG, ADD, 7, 32'h0, 32'h0, 32'h9);
    check("halt_ignored_reg_rd", reg_rd, 0);
    check("halt_sticky", halt, 1);
    issue(0, MEM, LW, 7, 32'h0, 32'h0, 32'h60);
    check("halt_ignored_mem", mem_wr, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
